// File: rtl/sha3_pkg.sv
// Shared definitions for the SHA3-512 input path.
//   RATE_BYTES_512 : bytes per SHA3-512 rate block
//   PAD_DOMAIN     : domain-separation byte that opens the padding
//   PAD_FINAL      : bit OR-ed into the last byte of the final block
//   state_e        : packer FSM states
package sha3_pkg;

  localparam int unsigned RATE_BYTES_512 = 72;
  localparam logic [7:0]  PAD_DOMAIN     = 8'h06;
  localparam logic [7:0]  PAD_FINAL      = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PAD,
    OUT
  } state_e;

endpackage

// File: rtl/sha3_block_packer.sv
// Pops message bytes from an 8-bit FIFO and packs them into SHA3-512 rate
// blocks. The final block is padded with 0x06 ... 0x80.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   start, msg_len    : start pulse and message length (bytes, 0 legal)
//   fifo_dout         : FIFO read data, valid one cycle after fifo_rd
//   fifo_empty        : FIFO empty flag
//   fifo_rd           : FIFO read strobe
//   block_data        : packed block, byte i at bits [8i+7:8i]
//   block_valid       : block_data holds a complete block
//   block_last        : final (padded) block, qualifies block_valid
//   block_ready       : downstream accepts the block
//   busy              : message in progress
module sha3_block_packer
  import sha3_pkg::*;
#(
  parameter int unsigned RATE_BYTES = RATE_BYTES_512,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        msg_len,
  input  logic [7:0]              fifo_dout,
  input  logic                    fifo_empty,
  output logic                    fifo_rd,
  output logic [8*RATE_BYTES-1:0] block_data,
  output logic                    block_valid,
  output logic                    block_last,
  input  logic                    block_ready,
  output logic                    busy
);

  localparam logic [6:0] RATE_N = 7'(RATE_BYTES);

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [LEN_W-1:0]        itot_q, itot_d;
  logic [6:0]              bidx_q, bidx_d;
  logic [6:0]              iblk_q, iblk_d;
  logic                    rd_q, rd_d;
  logic                    last_q, last_d;
  logic [8*RATE_BYTES-1:0] buf_q, buf_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FILL;
      end
      FILL: begin
        // Block full takes priority, so an exact multiple of the rate first
        // emits its data block and pads afterwards from OUT.
        if (bidx_q == RATE_N) begin
          state_d = OUT;
        end else if (rem_q == '0 && !rd_q) begin
          state_d = PAD;
        end
      end
      PAD: begin
        state_d = OUT;
      end
      OUT: begin
        if (block_ready) begin
          if (last_q)              state_d = IDLE;
          else if (rem_q != '0)    state_d = FILL;
          else                     state_d = PAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    fifo_rd     = (state_q == FILL) && !fifo_empty &&
                  (iblk_q < RATE_N) && (itot_q < len_q);
    block_valid = (state_q == OUT);
    block_last  = (state_q == OUT) && last_q;
    busy        = (state_q != IDLE);
  end

  assign block_data = buf_q;

  // Datapath next-state
  always_comb begin
    len_d  = len_q;
    rem_d  = rem_q;
    itot_d = itot_q;
    bidx_d = bidx_q;
    iblk_d = iblk_q;
    last_d = last_q;
    buf_d  = buf_q;
    rd_d   = fifo_rd;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d  = msg_len;
          rem_d  = msg_len;
          itot_d = '0;
          bidx_d = '0;
          iblk_d = '0;
          last_d = 1'b0;
          buf_d  = '0;
        end
      end
      FILL: begin
        if (fifo_rd) begin
          itot_d = itot_q + LEN_W'(1);
          iblk_d = iblk_q + 7'd1;
        end
        // Read data lands one cycle after the strobe.
        if (rd_q) begin
          for (int unsigned i = 0; i < RATE_BYTES; i++) begin
            if (bidx_q == 7'(i)) buf_d[8*i +: 8] = fifo_dout;
          end
          bidx_d = bidx_q + 7'd1;
          rem_d  = rem_q - LEN_W'(1);
        end
      end
      PAD: begin
        // Both ORs are applied in order, so a shared lane ends up 0x86.
        for (int unsigned i = 0; i < RATE_BYTES; i++) begin
          if (bidx_q == 7'(i)) buf_d[8*i +: 8] = buf_d[8*i +: 8] | PAD_DOMAIN;
        end
        buf_d[8*(RATE_BYTES-1) +: 8] = buf_d[8*(RATE_BYTES-1) +: 8] | PAD_FINAL;
        last_d = 1'b1;
      end
      OUT: begin
        if (block_ready && !last_q) begin
          buf_d  = '0;
          bidx_d = '0;
          iblk_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q  <= '0;
      rem_q  <= '0;
      itot_q <= '0;
      bidx_q <= '0;
      iblk_q <= '0;
      rd_q   <= 1'b0;
      last_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      len_q  <= len_d;
      rem_q  <= rem_d;
      itot_q <= itot_d;
      bidx_q <= bidx_d;
      iblk_q <= iblk_d;
      rd_q   <= rd_d;
      last_q <= last_d;
      buf_q  <= buf_d;
    end
  end

endmodule

// File: tb/tb_sha3_block_packer.sv
// Scoreboard bench for sha3_block_packer: a FIFO model feeds bytes, expected
// padded blocks are queued when a message is issued, and a monitor compares
// every accepted block against the queue.
module tb_sha3_block_packer;

  localparam int RB = 72;
  localparam int LW = 16;

  typedef struct packed {
    logic [8*RB-1:0] data;
    logic            last;
  } blk_t;

  logic            clk;
  logic            rst;
  logic            start;
  logic [LW-1:0]   msg_len;
  logic [7:0]      fifo_dout;
  logic            fifo_empty;
  logic            fifo_rd;
  logic [8*RB-1:0] block_data;
  logic            block_valid;
  logic            block_last;
  logic            block_ready;
  logic            busy;

  int   tests = 0;
  int   fails = 0;
  logic [7:0] fifo_q[$];
  blk_t sb_q[$];
  int   cyc = 0;
  int   rd_count = 0;
  int   first_rd = -1;
  int   last_rd = -1;
  int   start_cyc = 0;
  bit   gaps_en = 0;
  int   ready_delay = 0;
  int   wcnt = 0;
  bit   stall_prev = 0;
  logic [8*RB-1:0] held_data;
  logic            held_last;

  sha3_block_packer #(.RATE_BYTES(RB), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .msg_len    (msg_len),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .block_data (block_data),
    .block_valid(block_valid),
    .block_last (block_last),
    .block_ready(block_ready),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [8*RB-1:0] act, input logic [8*RB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: message, then 0x06, zero-fill to a rate multiple, 0x80 OR-ed
  // into the very last byte; split into rate-sized blocks.
  task automatic push_expected(input logic [7:0] msg[$]);
    logic [7:0] s[$];
    int nblk;
    blk_t e;
    s = msg;
    s.push_back(8'h06);
    while (s.size() % RB != 0) s.push_back(8'h00);
    s[s.size()-1] = s[s.size()-1] | 8'h80;
    nblk = s.size() / RB;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < RB; i++) e.data[8*i +: 8] = s[b*RB + i];
      e.last = (b == nblk - 1);
      sb_q.push_back(e);
    end
  endtask

  // FIFO model: registered read data, optional random empty gaps.
  always @(posedge clk) begin
    cyc++;
    if (rst && fifo_rd) begin
      tests++;
      if (fifo_empty || fifo_q.size() == 0) begin
        fails++;
        $display("FAIL rd_when_empty: fifo_rd=1 with fifo_empty=%0d depth=%0d", fifo_empty, fifo_q.size());
      end else begin
        fifo_dout <= fifo_q.pop_front();
      end
      rd_count++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    #1;
    fifo_empty = (fifo_q.size() == 0) || (gaps_en && $urandom_range(0, 2) == 0);
  end

  // Downstream ready: fixed stall per block, or random when ready_delay < 0.
  always @(posedge clk) begin
    #1;
    if (!block_valid) begin
      block_ready = 1'b0;
      wcnt = 0;
    end else if (ready_delay < 0) begin
      block_ready = 1'($urandom_range(0, 1));
    end else if (wcnt < ready_delay) begin
      block_ready = 1'b0;
      wcnt++;
    end else begin
      block_ready = 1'b1;
    end
  end

  // Monitor: mid-cycle sampling of the handshake and OUT-state invariants.
  always @(negedge clk) begin
    if (rst) begin
      if (stall_prev) begin
        chk("hold_valid", {575'd0, block_valid}, {575'd0, 1'b1});
        chk("hold_data", block_data, held_data);
        chk("hold_last", {575'd0, block_last}, {575'd0, held_last});
      end
      if (block_valid) chk("no_rd_in_out", {575'd0, fifo_rd}, '0);
      if (block_valid && block_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_block: got block last=%0d expected none", block_last);
        end else begin
          blk_t e;
          e = sb_q.pop_front();
          chk("block_data", block_data, e.data);
          chk("block_last", {575'd0, block_last}, {575'd0, e.last});
        end
      end
      stall_prev = block_valid && !block_ready;
      held_data  = block_data;
      held_last  = block_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic do_start(input int len);
    @(posedge clk);
    #1;
    start     = 1'b1;
    msg_len   = LW'(len);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start   = 1'b0;
    msg_len = LW'($urandom);
  endtask

  task automatic run_msg(input int len, input bit rnd, input logic [7:0] base,
                         input bit gaps, input int rdly, input bit poke);
    logic [7:0] m[$];
    int t;
    for (int k = 0; k < len; k++) m.push_back(rnd ? 8'($urandom) : base + 8'(k));
    gaps_en     = gaps;
    ready_delay = rdly;
    foreach (m[k]) fifo_q.push_back(m[k]);
    push_expected(m);
    rd_count = 0;
    first_rd = -1;
    last_rd  = -1;
    @(posedge clk);
    do_start(len);
    chk("busy_after_start", {575'd0, busy}, {575'd0, 1'b1});
    if (poke) begin
      repeat (4) @(posedge clk);
      #1;
      start   = 1'b1;
      msg_len = 16'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    t = 0;
    while (busy && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 5000) chk_int("msg_timeout", t, 0);
    chk_int("rd_count", rd_count, len);
    chk_int("sb_drained", sb_q.size(), 0);
    chk_int("fifo_drained", fifo_q.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_data"}, block_data, '0);
    chk({tag, "_ctl"}, {571'd0, block_valid, block_last, fifo_rd, busy, 1'b0}, '0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    rst         = 1'b0;
    start       = 1'b0;
    msg_len     = '0;
    fifo_empty  = 1'b1;
    block_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b1;

    // Empty message: single pad-only block, no reads.
    run_msg(0, 1'b0, 8'h00, 1'b0, 0, 1'b0);

    // Three bytes: back-to-back reads starting one cycle after start.
    run_msg(3, 1'b0, 8'h61, 1'b0, 0, 1'b0);
    chk_int("first_rd_latency", first_rd - start_cyc, 2);
    chk_int("rd_consecutive", last_rd - first_rd, 2);

    // 71 bytes: domain and final pad share the last byte (0x86).
    run_msg(71, 1'b0, 8'h00, 1'b0, 1, 1'b0);

    // 72 bytes: full data block, then pad-only block.
    run_msg(72, 1'b1, 8'h00, 1'b0, 2, 1'b0);

    // 100 bytes with FIFO gaps, 5-cycle ready stall, ignored second start.
    run_msg(100, 1'b1, 8'h00, 1'b1, 5, 1'b1);

    // Random lengths, gaps and ready behaviour.
    for (int n = 0; n < 6; n++) begin
      run_msg(int'($urandom_range(0, 220)), 1'b1, 8'h00, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 3)), 1'b0);
    end

    // Asynchronous reset in the middle of a fill.
    gaps_en     = 1'b0;
    ready_delay = 0;
    for (int k = 0; k < 100; k++) fifo_q.push_back(8'(k));
    rd_count = 0;
    @(posedge clk);
    do_start(100);
    t = 0;
    while (rd_count < 10 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk_int("midfill_reached", (rd_count >= 10) ? 1 : 0, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero_outputs("midfill_reset");
    fifo_q.delete();
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run_msg(3, 1'b0, 8'h61, 1'b0, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sha3_block_packer.md
Name: sha3_block_packer

Overview:
- Reader at the far end of the 8-bit input FIFO.
- Pops message bytes from the FIFO and packs them into 576-bit SHA3-512 rate blocks (72 bytes) for the absorb stage.
- Applies SHA3 padding (0x06 … 0x80) to the final block.
- Message length is supplied by the controller at start.

Parameters:
- RATE_BYTES, 72, bytes per rate block (SHA3-512)
- LEN_W, 16, width of message-length input

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; latches msg_len; ignored unless idle
- msg_len  in  LEN_W  message length in bytes; 0 is legal
- fifo_dout  in  8  FIFO read data; registered, valid 1 cycle after an accepted read
- fifo_empty  in  1  FIFO EMPTY flag
- fifo_rd  out  1  FIFO RD strobe
- block_data  out  8*RATE_BYTES  packed block; byte i occupies bits [8i+7:8i]
- block_valid  out  1  block_data holds a complete block
- block_last  out  1  qualifies block_valid; final (padded) block of the message
- block_ready  in  1  downstream accepts the block when high together with block_valid
- busy  out  1  high from accepted start until the final block handshake

Behaviour:
- Reset (rst low, async):
  - State goes to IDLE; all counters clear.
  - block_data is all-zero; block_valid, block_last, fifo_rd and busy are 0.
  - FIFO contents are not touched. A FIFO read issued in the reset cycle is discarded.
- States:
  - IDLE: start → FILL. Latches msg_len, sets remaining = msg_len, clears the buffer and byte_idx, sets busy = 1.
  - FILL:
    - fifo_rd = !fifo_empty && issued_blk < RATE_BYTES && issued_tot < msg_len.
    - Each issued read sets rd_q the next cycle. On rd_q, fifo_dout is written to byte[byte_idx], then byte_idx increments and remaining decrements.
    - Reads may issue back-to-back, giving a throughput of 1 byte/clk.
  - FILL exits:
    - byte_idx == RATE_BYTES → OUT with block_last = 0.
    - remaining == 0, with no read in flight and byte_idx < RATE_BYTES → PAD.
    - msg_len == 0 goes straight to PAD. fifo_rd is never asserted in that case.
  - PAD (1 cycle):
    - byte[byte_idx] |= 0x06 and byte[RATE_BYTES-1] |= 0x80. If both land on the same byte, it becomes 0x86.
    - → OUT with block_last = 1.
  - OUT:
    - block_valid = 1. block_data and block_last are held stable until block_ready.
    - fifo_rd = 0 throughout OUT.
    - On handshake with last = 1 → IDLE, busy = 0.
    - On handshake with last = 0: clear the buffer and byte_idx. Go to FILL if remaining > 0; otherwise go to PAD, which produces the pad-only block for lengths that are exact multiples of 72.
- Latency: first fifo_rd 1 cycle after start, given a non-empty FIFO.
- FIFO empty mid-block: stall in FILL with no reads. Resume when not empty.
- start while busy: ignored. msg_len is sampled only on an accepted start.
- Widths: issued_tot and remaining are LEN_W bits. byte_idx and issued_blk are 7 bits and never exceed RATE_BYTES.

Decomposition:
- Shared package sha3_pkg holds:
  - RATE_BYTES_512 = 72
  - PAD_DOMAIN = 8'h06
  - PAD_FINAL = 8'h80
  - the state enum IDLE / FILL / PAD / OUT
- No sub-module. The byte-lane write decode stays inline.

Test Plan:
- msg_len=0, start → one block: byte0=0x06, byte71=0x80, all other bytes 0, block_last=1. fifo_rd never high.
- FIFO preloaded 61 62 63, msg_len=3 → bytes0..2 = 61 62 63, byte3=06, byte71=80, all others 0, last=1. Exactly 3 fifo_rd pulses, on consecutive cycles.
- msg_len=71, bytes 00..46 hex → one block with byte70=0x46 and byte71=0x86, last=1.
- msg_len=72 → block 1 carries all data with last=0. Block 2 has byte0=06, byte71=80, last=1.
- msg_len=100 with random fifo_empty gaps and block_ready held low 5 cycles → no fifo_rd while in OUT and block_data stable. Block 2 bytes0..27 carry data, byte28=06, byte71=80.
- rst low mid-FILL (after 10 bytes) → all outputs 0 immediately. A new start with msg_len=3 then completes correctly.
